// File: rtl/change_dispense_timer.sv
// Inactivity countdown plus greedy change dispenser: one coin per cycle, largest
// denomination first, bounded by an internally tracked per-denomination stock.
module change_dispense_timer #(
    parameter int                    NUM_COINS   = 3,
    parameter int                    NUM_ITEMS   = 4,
    parameter int                    TOTAL_BITS  = 31,
    parameter int                    WAIT_TIME   = 10,
    parameter logic [NUM_COINS*32-1:0] COIN_VALUES = {32'd1000, 32'd500, 32'd100},
    parameter int                    STOCK_BITS  = 8,
    parameter logic [STOCK_BITS-1:0] INIT_STOCK  = 8'd10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_output_item,
    input  logic                  i_trigger_return,
    input  logic [TOTAL_BITS-1:0] i_current_total,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [31:0]           o_wait_time,
    output logic                  o_busy,
    output logic                  o_change_done,
    output logic [TOTAL_BITS-1:0] o_residual
);

    localparam int                    CW        = (TOTAL_BITS > 32) ? TOTAL_BITS : 32;
    localparam logic [31:0]           WAIT_INIT = 32'(WAIT_TIME);
    localparam logic [STOCK_BITS-1:0] STOCK_MAX = {STOCK_BITS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNT    = 2'd1,
        S_DISPENSE = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                                r_state;
    logic [TOTAL_BITS-1:0]                 r_remaining;
    logic [NUM_COINS-1:0][STOCK_BITS-1:0]  r_stock;

    logic [NUM_COINS-1:0][STOCK_BITS-1:0]  w_stock_next;
    logic [NUM_COINS-1:0]                  w_sel_onehot;
    logic [TOTAL_BITS-1:0]                 w_sel_val;
    logic                                  w_sel_valid;
    logic                                  w_activity;

    assign w_activity = (|i_input_coin) | (|i_output_item);

    // Ascending scan so the last qualifying denomination (the largest) wins.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_onehot = '0;
        w_sel_val    = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if ((CW'(COIN_VALUES[k*32 +: 32]) <= CW'(r_remaining)) && (r_stock[k] != '0)) begin
                w_sel_valid     = 1'b1;
                w_sel_onehot    = '0;
                w_sel_onehot[k] = 1'b1;
                w_sel_val       = TOTAL_BITS'(COIN_VALUES[k*32 +: 32]);
            end
        end
    end

    always_comb begin
        w_stock_next = r_stock;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (i_input_coin[k] && (r_stock[k] != STOCK_MAX))
                w_stock_next[k] = r_stock[k] + 1'b1;
            if ((r_state == S_DISPENSE) && w_sel_onehot[k])
                w_stock_next[k] = w_stock_next[k] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stock <= {NUM_COINS{INIT_STOCK}};
        else
            r_stock <= w_stock_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            o_wait_time   <= WAIT_INIT;
            o_return_coin <= '0;
            o_busy        <= 1'b0;
            o_change_done <= 1'b0;
            o_residual    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_wait_time   <= WAIT_INIT;
                    o_return_coin <= '0;
                    o_busy        <= 1'b0;
                    o_change_done <= 1'b0;
                    if (i_current_total != '0)
                        r_state <= S_COUNT;
                end
                S_COUNT: begin
                    if (w_activity) begin
                        o_wait_time <= WAIT_INIT;
                    end else if (i_current_total == '0) begin
                        r_state     <= S_IDLE;
                        o_wait_time <= WAIT_INIT;
                    end else if (i_trigger_return || (o_wait_time == 32'd0)) begin
                        r_state     <= S_DISPENSE;
                        r_remaining <= i_current_total;
                        o_wait_time <= 32'd0;
                        o_busy      <= 1'b1;
                    end else begin
                        o_wait_time <= o_wait_time - 32'd1;
                    end
                end
                S_DISPENSE: begin
                    if (w_sel_valid) begin
                        o_return_coin <= w_sel_onehot;
                        r_remaining   <= r_remaining - w_sel_val;
                    end else begin
                        o_return_coin <= '0;
                        o_residual    <= r_remaining;
                        o_change_done <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_change_done <= 1'b0;
                    o_busy        <= 1'b0;
                    o_wait_time   <= WAIT_INIT;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
